// File: rtl/psum_writeback_ctrl.sv
// psum_writeback_ctrl: drains each PE's psum buffer in order, applies optional
// ReLU, and writes the words to consecutive global-buffer addresses.
module psum_writeback_ctrl #(
  parameter int unsigned N                        = 3,
  parameter int unsigned N_WIDTH                  = 2,
  parameter int unsigned PSUM_ADDR_WIDTH          = 5,
  parameter int unsigned GLOBAL_BUFFER_ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH               = 16
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                Start,
  input  logic [GLOBAL_BUFFER_ADDR_WIDTH-1:0] base_addr,
  input  logic [PSUM_ADDR_WIDTH:0]            psum_count,
  input  logic                                relu_en,
  output logic                                Busy,
  output logic                                Done,
  output logic                                psum_rd_en,
  output logic [N_WIDTH-1:0]                  psum_sel,
  output logic [PSUM_ADDR_WIDTH-1:0]          psum_rd_addr,
  input  logic [DATA_WIDTH-1:0]               psum_rd_data,
  output logic                                gb_wr_en,
  output logic [GLOBAL_BUFFER_ADDR_WIDTH-1:0] gb_wr_addr,
  output logic [DATA_WIDTH-1:0]               gb_wr_data,
  input  logic                                gb_wr_ready
);

  localparam int unsigned CNT_W = PSUM_ADDR_WIDTH + 1;
  localparam int unsigned GB_W  = GLOBAL_BUFFER_ADDR_WIDTH;
  localparam int unsigned DW    = DATA_WIDTH;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    CAP  = 3'd2,
    WR   = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t               state, state_n;
  logic [GB_W-1:0]      wr_addr, wr_addr_n;
  logic [CNT_W-1:0]     cnt, cnt_n;
  logic [CNT_W-1:0]     elem, elem_n;
  logic [N_WIDTH-1:0]   pe_idx, pe_idx_n;
  logic                 relu_q, relu_n;
  logic [DW-1:0]        hold, hold_n;

  logic                       busy_n, done_n, rd_en_n, wr_en_n;
  logic [N_WIDTH-1:0]         sel_n;
  logic [PSUM_ADDR_WIDTH-1:0] rd_addr_n;
  logic [GB_W-1:0]            gb_addr_n;
  logic [DW-1:0]              gb_data_n;

  // Next-state, datapath and next-output decode; outputs are registered from
  // the next state so every output is valid in the same cycle as its state.
  always_comb begin
    state_n   = state;
    wr_addr_n = wr_addr;
    cnt_n     = cnt;
    elem_n    = elem;
    pe_idx_n  = pe_idx;
    relu_n    = relu_q;
    hold_n    = hold;

    case (state)
      IDLE: begin
        if (Start) begin
          wr_addr_n = base_addr;
          cnt_n     = psum_count;
          relu_n    = relu_en;
          pe_idx_n  = '0;
          elem_n    = '0;
          state_n   = (psum_count == '0) ? DONE : RD;
        end
      end
      RD: state_n = CAP;
      CAP: begin
        hold_n  = (relu_q && psum_rd_data[DW-1]) ? '0 : psum_rd_data;
        state_n = WR;
      end
      WR: begin
        if (gb_wr_ready) begin
          wr_addr_n = wr_addr + GB_W'(1);
          if (elem == cnt - CNT_W'(1)) begin
            elem_n = '0;
            if (pe_idx == N_WIDTH'(N - 1)) begin
              state_n = DONE;
            end else begin
              pe_idx_n = pe_idx + N_WIDTH'(1);
              state_n  = RD;
            end
          end else begin
            elem_n  = elem + CNT_W'(1);
            state_n = RD;
          end
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase

    busy_n    = (state_n != IDLE);
    done_n    = (state_n == DONE);
    rd_en_n   = (state_n == RD);
    sel_n     = rd_en_n ? pe_idx_n : '0;
    rd_addr_n = rd_en_n ? elem_n[PSUM_ADDR_WIDTH-1:0] : '0;
    wr_en_n   = (state_n == WR);
    gb_addr_n = wr_en_n ? wr_addr_n : '0;
    gb_data_n = wr_en_n ? hold_n : '0;
  end

  // State, working registers and registered outputs; reset aborts at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      wr_addr      <= '0;
      cnt          <= '0;
      elem         <= '0;
      pe_idx       <= '0;
      relu_q       <= 1'b0;
      hold         <= '0;
      Busy         <= 1'b0;
      Done         <= 1'b0;
      psum_rd_en   <= 1'b0;
      psum_sel     <= '0;
      psum_rd_addr <= '0;
      gb_wr_en     <= 1'b0;
      gb_wr_addr   <= '0;
      gb_wr_data   <= '0;
    end else begin
      state        <= state_n;
      wr_addr      <= wr_addr_n;
      cnt          <= cnt_n;
      elem         <= elem_n;
      pe_idx       <= pe_idx_n;
      relu_q       <= relu_n;
      hold         <= hold_n;
      Busy         <= busy_n;
      Done         <= done_n;
      psum_rd_en   <= rd_en_n;
      psum_sel     <= sel_n;
      psum_rd_addr <= rd_addr_n;
      gb_wr_en     <= wr_en_n;
      gb_wr_addr   <= gb_addr_n;
      gb_wr_data   <= gb_data_n;
    end
  end

endmodule

// File: tb/tb_psum_writeback_ctrl.sv
// Bench for psum_writeback_ctrl: directed and randomized transfers checked
// against an address/data list built from the drain-order rules.
module tb_psum_writeback_ctrl;

  localparam int NPE = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        Start;
  logic [9:0]  base_addr;
  logic [5:0]  psum_count;
  logic        relu_en;
  logic        Busy, Done, psum_rd_en, gb_wr_en, gb_wr_ready;
  logic [1:0]  psum_sel;
  logic [4:0]  psum_rd_addr;
  logic [15:0] psum_rd_data;
  logic [9:0]  gb_wr_addr;
  logic [15:0] gb_wr_data;

  logic [15:0] mem [0:3][0:31];

  int n_assert = 0;
  int n_fail   = 0;

  psum_writeback_ctrl dut (
    .clk(clk), .rst(rst), .Start(Start), .base_addr(base_addr),
    .psum_count(psum_count), .relu_en(relu_en), .Busy(Busy), .Done(Done),
    .psum_rd_en(psum_rd_en), .psum_sel(psum_sel), .psum_rd_addr(psum_rd_addr),
    .psum_rd_data(psum_rd_data), .gb_wr_en(gb_wr_en), .gb_wr_addr(gb_wr_addr),
    .gb_wr_data(gb_wr_data), .gb_wr_ready(gb_wr_ready)
  );

  always #5 clk = ~clk;

  // Psum buffer model: one-cycle read latency, garbage when not reading.
  always @(posedge clk) begin
    if (psum_rd_en) psum_rd_data <= mem[psum_sel][psum_rd_addr];
    else            psum_rd_data <= 16'($urandom);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // mode: 0 ready always high, 1 five-cycle stall on 2nd write, 2 random ready
  task automatic run_xfer(input logic [9:0] base, input logic [5:0] cnt, input logic rl,
                          input int mode, input bit start_busy, input bit start_done,
                          output int done_cyc);
    logic [9:0]  qa[$];
    logic [15:0] qd[$];
    int stalls = 0, nwr = 0, nrd = 0, bad = 0, stall_left = 5, exp_cyc;
    for (int pe = 0; pe < NPE; pe++) begin
      for (int j = 0; j < int'(cnt); j++) begin
        qa.push_back(10'((int'(base) + pe * int'(cnt) + j) % 1024));
        qd.push_back((rl && $signed(mem[pe][j]) < 0) ? 16'd0 : mem[pe][j]);
      end
    end
    done_cyc = -1;
    @(negedge clk);
    base_addr = base; psum_count = cnt; relu_en = rl; Start = 1'b1; gb_wr_ready = 1'b1;
    @(posedge clk);
    #1;
    Start = 1'b0;
    base_addr = 10'($urandom); psum_count = 6'($urandom); relu_en = 1'($urandom);
    for (int c = 1; c <= 800 && done_cyc < 0; c++) begin
      @(negedge clk);
      if (mode == 1)      gb_wr_ready = !(gb_wr_en && nwr == 1 && stall_left > 0);
      else if (mode == 2) gb_wr_ready = ($urandom_range(0, 3) != 0);
      else                gb_wr_ready = 1'b1;
      if (gb_wr_en && !gb_wr_ready) begin
        stalls++;
        if (mode == 1) stall_left--;
        if (qa.size() == 0 || gb_wr_addr !== qa[0] || gb_wr_data !== qd[0]) bad++;
      end
      if (gb_wr_en && gb_wr_ready) begin
        if (qa.size() == 0) bad++;
        else begin
          check("wr_addr", 32'(gb_wr_addr), 32'(qa[0]));
          check("wr_data", 32'(gb_wr_data), 32'(qd[0]));
          void'(qa.pop_front());
          void'(qd.pop_front());
        end
        nwr++;
      end
      if (psum_rd_en) nrd++;
      else if (psum_sel != 2'd0 || psum_rd_addr != 5'd0) bad++;
      if (!Busy) bad++;
      if (start_busy) begin
        Start = (c == 5);
        base_addr = 10'($urandom);
      end
      if (Done) begin
        done_cyc = c;
        if (start_done) Start = 1'b1;
      end
    end
    @(negedge clk);
    Start = 1'b0;
    exp_cyc = 3 * NPE * int'(cnt) + 1 + stalls;
    check("done_latency", 32'(done_cyc), 32'(exp_cyc));
    check("write_count", 32'(nwr), 32'(NPE * int'(cnt)));
    check("read_count", 32'(nrd), 32'(NPE * int'(cnt)));
    check("protocol_errs", 32'(bad), 32'd0);
    check("busy_after_done", 32'(Busy), 32'd0);
    check("done_one_cycle", 32'(Done), 32'd0);
    if (mode == 1) check("stall_cycles", 32'(stalls), 32'd5);
  endtask

  initial begin
    int dc;
    int waited;
    int bad;
    logic [9:0]  b;
    logic [5:0]  n;
    rst = 1'b1; Start = 1'b0; base_addr = '0; psum_count = '0; relu_en = 1'b0;
    gb_wr_ready = 1'b1;
    for (int pe = 0; pe < 4; pe++)
      for (int j = 0; j < 32; j++) mem[pe][j] = 16'(10 * pe + j);
    repeat (3) @(posedge clk);
    #1;
    check("reset_ctrl", 32'({Busy, Done, psum_rd_en, psum_sel, psum_rd_addr, gb_wr_en}), 32'd0);
    check("reset_gb", 32'({gb_wr_addr, gb_wr_data}), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Basic drain: 12 words, addresses 100..111.
    run_xfer(10'd100, 6'd4, 1'b0, 0, 1'b0, 1'b0, dc);
    check("basic_done_37", 32'(dc), 32'd37);

    // ReLU on PE1 negative words, then the same words pass through without ReLU.
    mem[1][0] = 16'hFFFB; mem[1][1] = 16'd7; mem[1][2] = 16'hFFFF; mem[1][3] = 16'd0;
    run_xfer(10'd100, 6'd4, 1'b1, 0, 1'b0, 1'b0, dc);
    run_xfer(10'd100, 6'd4, 1'b0, 0, 1'b0, 1'b0, dc);

    // Five-cycle stall on the 2nd write, with a Start coincident with DONE.
    run_xfer(10'd100, 6'd4, 1'b0, 1, 1'b0, 1'b1, dc);
    check("stall_done_42", 32'(dc), 32'd42);

    // Address wrap.
    run_xfer(10'd1022, 6'd2, 1'b0, 0, 1'b0, 1'b0, dc);

    // Empty drain.
    run_xfer(10'd5, 6'd0, 1'b0, 0, 1'b0, 1'b0, dc);
    check("empty_done_1", 32'(dc), 32'd1);

    // Reset in the middle of a write stall.
    @(negedge clk);
    base_addr = 10'd200; psum_count = 6'd4; relu_en = 1'b0; Start = 1'b1;
    @(posedge clk);
    #1;
    Start = 1'b0; gb_wr_ready = 1'b0;
    waited = 0;
    while (!gb_wr_en && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check("reached_wr", 32'(gb_wr_en), 32'd1);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_rst_ctrl", 32'({Busy, Done, psum_rd_en, psum_sel, psum_rd_addr, gb_wr_en}), 32'd0);
    check("async_rst_gb", 32'({gb_wr_addr, gb_wr_data}), 32'd0);
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (Done) bad++;
    end
    rst = 1'b0; gb_wr_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (Done || Busy) bad++;
    end
    check("no_done_after_rst", 32'(bad), 32'd0);

    // Full transfer after reset with a Start pulse while busy.
    for (int pe = 0; pe < 4; pe++)
      for (int j = 0; j < 32; j++) mem[pe][j] = 16'($urandom);
    run_xfer(10'd300, 6'd5, 1'b1, 0, 1'b1, 1'b0, dc);

    // Randomized transfers with random backpressure.
    for (int t = 0; t < 6; t++) begin
      for (int pe = 0; pe < 4; pe++)
        for (int j = 0; j < 32; j++) mem[pe][j] = 16'($urandom);
      b = 10'($urandom);
      n = 6'($urandom_range(1, 32));
      run_xfer(b, n, 1'($urandom), 2, 1'($urandom), 1'($urandom), dc);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/psum_writeback_ctrl.md
Name: psum_writeback_ctrl

Overview:
Drains the PE array's partial-sum buffers back into the global buffer after a PE_generator run finishes. It reads each PE's psum buffer in turn, optionally applies ReLU, and writes results to consecutive global-buffer addresses starting at a base address. It is the reader/return path for the psum data the PEs write. It is launched by the top-level controller with a Start/Done handshake once the array reports Done.

Parameters:
N, 3, number of PEs (psum buffers) to drain
N_WIDTH, 2, width of PE index
PSUM_ADDR_WIDTH, 5, psum buffer address width
GLOBAL_BUFFER_ADDR_WIDTH, 10, global buffer address width
DATA_WIDTH, 16, psum word width (two's complement)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
Start  in  1  launch request, sampled only in IDLE
base_addr  in  GLOBAL_BUFFER_ADDR_WIDTH  first global-buffer write address
psum_count  in  PSUM_ADDR_WIDTH+1  words per PE buffer to drain
relu_en  in  1  clamp negative results to 0
Busy  out  1  high in any state other than IDLE
Done  out  1  one-cycle completion pulse
psum_rd_en  out  1  psum buffer read strobe
psum_sel  out  N_WIDTH  PE index being read
psum_rd_addr  out  PSUM_ADDR_WIDTH  psum buffer word address
psum_rd_data  in  DATA_WIDTH  read data, valid the cycle after psum_rd_en
gb_wr_en  out  1  global-buffer write request
gb_wr_addr  out  GLOBAL_BUFFER_ADDR_WIDTH  write address
gb_wr_data  out  DATA_WIDTH  write data
gb_wr_ready  in  1  global buffer accepts the write this cycle

Behaviour:
- Reset (async, rst=1): state=IDLE. All outputs are 0. Internal counters and the hold register are 0. A reset mid-transfer aborts immediately. No Done pulse is produced. Writes already accepted are not undone.
- All outputs are registered or decoded from the state register only. There is no combinational path from gb_wr_ready to any output.
- States: IDLE, RD, CAP, WR, DONE.
- IDLE: On Start=1 at a clock edge:
  - Latch base_addr into wr_addr, psum_count into cnt, and relu_en.
  - Clear pe_idx and elem.
  - Go to RD. If psum_count==0, go to DONE instead.
  - Start in any other state is ignored and is not queued.
- RD: psum_rd_en=1, psum_sel=pe_idx, psum_rd_addr=elem. Next state: CAP.
- CAP: Capture psum_rd_data into the hold register. If the relu flag is set and bit DATA_WIDTH-1 is 1, store 0 instead. Next state: WR.
- WR: gb_wr_en=1, gb_wr_addr=wr_addr, gb_wr_data=hold.
  - Hold all three stable while gb_wr_ready=0.
  - On a cycle with gb_wr_ready=1, the write is accepted and wr_addr increments by 1, wrapping modulo 2^GLOBAL_BUFFER_ADDR_WIDTH.
  - If elem==cnt-1: clear elem. Then if pe_idx==N-1, go to DONE; otherwise increment pe_idx and go to RD.
  - Otherwise increment elem and go to RD.
- DONE: Done=1 for exactly one cycle, Busy=1. Next state: IDLE. A Start coincident with DONE is ignored.
- Throughput: 3 cycles per word with gb_wr_ready held high.
- Total latency from the Start-sampling edge to Done high is N*psum_count*3+1 cycles, plus one cycle per stalled WR cycle.
- Write order: PE0 words 0..cnt-1, then PE1, and so on. Global address = base + pe*cnt + elem (mod 2^width).
- psum_rd_en, psum_sel and psum_rd_addr are 0 outside RD.
- gb_wr_en is 0 outside WR. gb_wr_addr and gb_wr_data are don't-care when gb_wr_en=0.
- Inputs base_addr, psum_count and relu_en may change while Busy without effect.

Test Plan:
- N=3, psum_count=4, base_addr=100, relu_en=0, gb_wr_ready=1, buffer PEk word j = 10k+j → 12 writes to addresses 100..111 with data 0,1,2,3,10,11,12,13,20,21,22,23. Done pulses exactly 37 cycles after the Start edge. Busy is high throughout.
- Same setup, relu_en=1, PE1 words = -5,7,-1,0 → addresses 104..107 receive 0,7,0,0. Negative values are unchanged when relu_en=0.
- gb_wr_ready low for 5 cycles on the 2nd write → gb_wr_en, addr and data held stable for the 5 stall cycles. No duplicate or lost write. Done arrives 5 cycles later (42).
- base_addr=1022, psum_count=2, N=3 → write addresses 1022,1023,0,1,2,3 (wrap).
- psum_count=0 → no psum_rd_en and no gb_wr_en. Done pulses on the 2nd edge after Start (IDLE→DONE→IDLE).
- rst asserted in the middle of a WR stall → outputs are 0 asynchronously and no Done pulse occurs. After release, a new Start runs a full correct transfer. A Start pulse while Busy is ignored.
